// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs the data-memory handshake for the load/store held in EX/MEM,
// aligns load/store data to byte lanes and generates the global pipeline advance strobe.
module mem_stage_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_req,
    input  logic             mem_write_req,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [1:0]       bit_shift,
    input  logic [3:0]       mbe_in,
    input  logic [31:0]      wdata_in,
    input  logic             imem_ready,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [31:0]      dmem_address,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_mbe,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic             pipe_load,
    output logic [31:0]      load_data,
    output logic             misaligned,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] hold_data;
    logic        req, is_word, is_half, mis, legal;
    logic        strobe, pl, latch;
    logic [31:0] ld_src, ld_shifted, ld_ext;

    // Handshake: a legal request is held steady by EX/MEM until pipe_load advances it;
    // dmem_resp is a single-cycle pulse that completes the outstanding strobe.
    assign req     = mem_read_req | mem_write_req;
    assign is_word = (funct3[1:0] == 2'b10);
    assign is_half = (funct3[1:0] == 2'b01);
    assign mis     = req && ((is_word && (bit_shift != 2'd0)) || (is_half && (bit_shift == 2'd3)));
    assign legal   = req && !mis;

    always_comb begin
        state_nx = state;
        strobe   = 1'b0;
        pl       = 1'b0;
        latch    = 1'b0;
        case (state)
            IDLE, ACCESS: begin
                if (!legal) begin
                    pl       = (state == IDLE) ? imem_ready : 1'b0;
                    state_nx = IDLE;
                end else begin
                    strobe = 1'b1;
                    if (!dmem_resp) begin
                        state_nx = ACCESS;
                    end else if (imem_ready) begin
                        pl       = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        latch    = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                pl = imem_ready;
                if (imem_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_data    <= 32'd0;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            if (latch) hold_data <= dmem_rdata;
            // Only dmem-caused stalls count; HOLD waits are purely on the fetch side.
            if (legal && !pl && (state != HOLD)) stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign ld_src     = (state == HOLD) ? hold_data : dmem_rdata;
    assign ld_shifted = ld_src >> {bit_shift, 3'b000};

    always_comb begin
        ld_ext = ld_shifted;
        case (funct3)
            3'b000:  ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shifted[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shifted[15:0]};
            default: ld_ext = ld_shifted;
        endcase
    end

    assign dmem_write   = !rst && strobe && mem_write_req;
    assign dmem_read    = !rst && strobe && !mem_write_req;
    assign dmem_address = addr;
    assign dmem_wdata   = wdata_in << {bit_shift, 3'b000};
    assign dmem_mbe     = dmem_write ? mbe_in : (dmem_read ? 4'b1111 : 4'b0000);
    assign pipe_load    = !rst && pl;
    assign load_data    = legal ? ld_ext : 32'd0;
    assign misaligned   = !rst && mis && (state == IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases plus random load/store transactions compared
// against a transaction-level model of latency, fetch hold-off and data alignment.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_req, mem_write_req;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [1:0]  bit_shift;
  logic [3:0]  mbe_in;
  logic [31:0] wdata_in;
  logic        imem_ready;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        pipe_load;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] stall_cycles;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_stall;
  logic [31:0] exp_q[$];

  mem_stage_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .funct3(funct3), .addr(addr), .bit_shift(bit_shift),
    .mbe_in(mbe_in), .wdata_in(wdata_in), .imem_ready(imem_ready),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .pipe_load(pipe_load), .load_data(load_data), .misaligned(misaligned),
    .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: an access crosses the word boundary if offset + size exceeds 4 bytes
  function automatic bit model_mis(input logic [2:0] f3, input logic [1:0] bs);
    int size;
    size = 1 << f3[1:0];
    return (int'(bs) + size) > 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] bs,
                                             input logic [31:0] rd);
    longint unsigned w, b, h;
    w = rd;
    b = (w >> (8 * bs)) % 256;
    h = (w >> (8 * bs)) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] bs);
    longint unsigned v;
    v = wd;
    v = v * (64'd1 << (8 * bs));
    return 32'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one cycle with no request: pipeline follows fetch, counter holds
  task automatic idle_cycle(input string tag);
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    dmem_resp     = 1'b0;
    dmem_rdata    = $urandom;
    imem_ready    = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, ".idle_pipe_load"}, 32'(pipe_load), 32'(imem_ready));
    check({tag, ".idle_strobes"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    check({tag, ".idle_mbe"}, 32'(dmem_mbe), 32'd0);
    check({tag, ".stall_cycles"}, stall_cycles, exp_stall);
    step();
  endtask

  // driver + per-cycle scoreboard for one load/store; lat = cycles before resp,
  // hold = cycles after resp that fetch keeps stalling
  task automatic run_txn(input string tag, input bit wr, input bit both, input logic [2:0] f3,
                         input logic [31:0] a, input logic [1:0] bs, input logic [3:0] mbe,
                         input logic [31:0] wd, input int lat, input int hold,
                         input logic [31:0] rd);
    bit pl_exp;
    mem_write_req = wr;
    mem_read_req  = !wr || both;
    funct3        = f3;
    addr          = a;
    bit_shift     = bs;
    mbe_in        = mbe;
    wdata_in      = wd;
    if (model_mis(f3, bs)) begin
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
      imem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, ".misaligned"}, 32'(misaligned), 32'd1);
      check({tag, ".mis_strobes"}, {30'd0, dmem_read, dmem_write}, 32'd0);
      check({tag, ".mis_pipe_load"}, 32'(pipe_load), 32'(imem_ready));
      check({tag, ".mis_load_data"}, load_data, 32'd0);
      check({tag, ".mis_stall"}, stall_cycles, exp_stall);
      step();
    end else begin
      if (!wr) exp_q.push_back(model_load(f3, bs, rd));
      for (int c = 0; c <= lat + hold; c++) begin
        dmem_resp  = (c == lat);
        dmem_rdata = (c == lat) ? rd : $urandom;
        imem_ready = (c < lat) ? 1'($urandom_range(0, 1)) : (c == lat + hold);
        pl_exp     = (c == lat + hold);
        @(negedge clk);
        check({tag, ".dmem_write"}, 32'(dmem_write), 32'(wr && c <= lat));
        check({tag, ".dmem_read"}, 32'(dmem_read), 32'(!wr && c <= lat));
        check({tag, ".pipe_load"}, 32'(pipe_load), 32'(pl_exp));
        check({tag, ".dmem_mbe"}, 32'(dmem_mbe),
              (c > lat) ? 32'd0 : (wr ? 32'(mbe) : 32'hF));
        check({tag, ".dmem_address"}, dmem_address, a);
        check({tag, ".dmem_wdata"}, dmem_wdata, model_wdata(wd, bs));
        check({tag, ".misaligned_low"}, 32'(misaligned), 32'd0);
        if (pl_exp && !wr) check({tag, ".load_data"}, load_data, exp_q.pop_front());
        if (c <= lat && !pl_exp) exp_stall++;
        step();
      end
    end
    idle_cycle(tag);
  endtask

  initial begin
    rst           = 1'b1;
    mem_read_req  = 1'b1;
    mem_write_req = 1'b0;
    funct3        = 3'd2;
    addr          = 32'h100;
    bit_shift     = 2'd0;
    mbe_in        = 4'hF;
    wdata_in      = 32'd0;
    imem_ready    = 1'b1;
    dmem_resp     = 1'b1;
    dmem_rdata    = 32'd0;
    exp_stall     = 32'd0;

    // strobes and advance stay low while reset is held, even with a request present
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset.pipe_load", 32'(pipe_load), 32'd0);
      check("reset.strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
      check("reset.misaligned", 32'(misaligned), 32'd0);
      step();
    end
    @(negedge clk);
    check("reset.stall_cycles", stall_cycles, 32'd0);
    step();
    rst = 1'b0;
    idle_cycle("post_reset");

    // directed cases
    run_txn("lw_lat3", 1'b0, 1'b0, 3'd2, 32'h100, 2'd0, 4'hF, 32'd0, 3, 0, 32'hDEADBEEF);
    check("lw_lat3.stall_total", stall_cycles, 32'd3);
    run_txn("lb_bs3", 1'b0, 1'b0, 3'd0, 32'h200, 2'd3, 4'hF, 32'd0, 1, 0, 32'h80112233);
    run_txn("lbu_bs3", 1'b0, 1'b0, 3'd4, 32'h200, 2'd3, 4'hF, 32'd0, 0, 0, 32'h80112233);
    run_txn("sh_bs2", 1'b1, 1'b0, 3'd1, 32'h300, 2'd2, 4'b1100, 32'h0000ABCD, 2, 0, 32'd0);
    run_txn("lw_hold2", 1'b0, 1'b0, 3'd2, 32'h400, 2'd0, 4'hF, 32'd0, 1, 2, 32'h12345678);
    run_txn("lw_mis", 1'b0, 1'b0, 3'd2, 32'h500, 2'd1, 4'hF, 32'd0, 0, 0, 32'd0);
    run_txn("lh_mis", 1'b0, 1'b0, 3'd1, 32'h500, 2'd3, 4'hF, 32'd0, 0, 0, 32'd0);
    run_txn("lh_bs1", 1'b0, 1'b0, 3'd1, 32'h500, 2'd1, 4'hF, 32'd0, 0, 1, 32'h00F0E100);
    run_txn("sw_both", 1'b1, 1'b1, 3'd2, 32'h600, 2'd0, 4'hF, 32'hCAFEF00D, 0, 3, 32'd0);

    // reset while an access is outstanding
    mem_read_req  = 1'b1;
    mem_write_req = 1'b0;
    funct3        = 3'd2;
    addr          = 32'h700;
    bit_shift     = 2'd0;
    dmem_resp     = 1'b0;
    imem_ready    = 1'b1;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_access.strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("rst_access.pipe_load", 32'(pipe_load), 32'd0);
    step();
    rst       = 1'b0;
    exp_stall = 32'd0;
    idle_cycle("rst_access");
    run_txn("after_rst", 1'b0, 1'b0, 3'd2, 32'h704, 2'd0, 4'hF, 32'd0, 0, 0, 32'h0BADF00D);

    // random transactions
    for (int i = 0; i < 60; i++) begin
      bit          wr, both;
      logic [2:0]  f3;
      logic [2:0]  ld_codes [5];
      ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      wr   = 1'($urandom_range(0, 1));
      both = wr && ($urandom_range(0, 3) == 0);
      f3   = wr ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      run_txn("rand", wr, both, f3, $urandom & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)),
              4'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
